reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_pkg.sv | 28 ++
 rtl/debouncer.sv | 63 ++++++
 rtl/reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_reset_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reset_pkg
// Brief    : Shared sequencer state, reset-cause encoding and counter sizing.
// Revision : 1.0
// ============================================================================
package reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR       = 2'd0,
        CAUSE_LOCK_LOSS = 2'd1,
        CAUSE_BUTTON    = 2'd2
    } reset_cause_e;

    // Bits needed to hold 0..max_count; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
// Module   : debouncer
// Brief    : Two-flop synchroniser plus stable-count filter for one button.
// Revision : 1.0
// ============================================================================
module debouncer
    import reset_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic btn_i,
    output logic pressed_o
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic             level;
    logic             sync1_q;
    logic             sync2_q;
    logic             pressed_q;
    logic             pressed_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Normalise polarity ahead of the synchroniser so a cleared flop means released.
    assign level = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = '0;
        if (sync2_q != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= level;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pressed_o = pressed_q;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Combines PLL lock and debounced buttons into staged domain resets.
// Revision : 1.0
// ============================================================================
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 1,
    parameter int unsigned BTN_ACTIVE_LOW  = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HOLD_CYCLES     = 31,
    parameter int unsigned NUM_DOMAINS     = 2,
    parameter int unsigned STAGE_GAP       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n_i,
    input  logic                   locked_i,
    input  logic [NUM_BTN-1:0]     btn_i,
    output logic [NUM_DOMAINS-1:0] reset_o,
    output logic                   ready_o,
    output logic [1:0]             cause_o
);

    localparam int unsigned HOLD_W  = cnt_width(HOLD_CYCLES);
    localparam int unsigned GAP_MAX = (STAGE_GAP > 1) ? STAGE_GAP - 1 : 0;
    localparam int unsigned GAP_W   = cnt_width(GAP_MAX);
    localparam int unsigned IDX_W   = cnt_width(NUM_DOMAINS - 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0]  IDX_FIRST = (NUM_DOMAINS > 1) ? IDX_W'(1) : '0;

    logic                   lock_s1_q;
    logic                   lock_s2_q;
    logic [NUM_BTN-1:0]     btn_pressed;
    logic                   request;

    seq_state_e             state_q,    state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q,  gap_cnt_d;
    logic [IDX_W-1:0]       idx_q,      idx_d;
    logic [NUM_DOMAINS-1:0] reset_q,    reset_d;
    logic                   ready_q,    ready_d;
    reset_cause_e           cause_q,    cause_d;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        debouncer #(
            .ACTIVE_LOW      (BTN_ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk       (clk),
            .reset_n_i (reset_n_i),
            .btn_i     (btn_i[b]),
            .pressed_o (btn_pressed[b])
        );
    end

    assign request = ~lock_s2_q | (|btn_pressed);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;
        reset_d    = reset_q;
        ready_d    = 1'b0;
        cause_d    = cause_q;

        if ((state_q != WAIT_LOCK) && request) begin
            state_d    = WAIT_LOCK;
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            idx_d      = '0;
            reset_d    = '1;
            cause_d    = lock_s2_q ? CAUSE_BUTTON : CAUSE_LOCK_LOSS;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    reset_d = '1;
                    if (!request) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        reset_d[0] = 1'b0;
                        gap_cnt_d  = '0;
                        idx_d      = IDX_FIRST;
                        state_d    = (NUM_DOMAINS > 1) ? RELEASE : RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        reset_d[idx_q] = 1'b0;
                        gap_cnt_d      = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    reset_d = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_s1_q  <= 1'b0;
            lock_s2_q  <= 1'b0;
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            reset_q    <= '1;
            ready_q    <= 1'b0;
            cause_q    <= CAUSE_POR;
        end else begin
            lock_s1_q  <= locked_i;
            lock_s2_q  <= lock_s1_q;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            idx_q      <= idx_d;
            reset_q    <= reset_d;
            ready_q    <= ready_d;
            cause_q    <= cause_d;
        end
    end

    assign reset_o = reset_q;
    assign ready_o = ready_q;
    assign cause_o = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Self-checking bench: POR timing table, corner sequences, random run.
// Revision : 1.0
// ============================================================================
module tb_reset_sequencer;

    localparam int NB   = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int ND   = 3;
    localparam int GAP  = 2;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          locked  = 1'b0;
    logic [NB-1:0] btn     = '1;
    logic [ND-1:0] rst_o;
    logic          rdy_o;
    logic [1:0]    cause_o;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_BTN         (NB),
        .BTN_ACTIVE_LOW  (1),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .NUM_DOMAINS     (ND),
        .STAGE_GAP       (GAP)
    ) dut (
        .clk       (clk),
        .reset_n_i (reset_n),
        .locked_i  (locked),
        .btn_i     (btn),
        .reset_o   (rst_o),
        .ready_o   (rdy_o),
        .cause_o   (cause_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: release times expressed as offsets from the edge that
    // leaves the waiting state; buttons filtered over a window of samples.
    logic          m_lk1, m_lk2;
    logic [NB-1:0] m_p1, m_p2, m_deb;
    logic [DEB-1:0] m_hist [NB];
    bit            m_wait;
    int            m_t;
    logic [1:0]    m_cause;

    always @(posedge clk or negedge reset_n) begin : model
        logic req;
        logic lk_now;
        if (!reset_n) begin
            m_lk1 = 0; m_lk2 = 0; m_p1 = '0; m_p2 = '0; m_deb = '0;
            for (int b = 0; b < NB; b++) m_hist[b] = '0;
            m_wait = 1; m_t = 0; m_cause = 2'd0;
        end else begin
            req    = !m_lk2 || (m_deb != '0);
            lk_now = m_lk2;
            for (int b = 0; b < NB; b++) begin
                m_hist[b] = {m_hist[b][DEB-2:0], m_p2[b]};
                if (m_hist[b] == {DEB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
            end
            m_p2 = m_p1; m_p1 = ~btn;
            m_lk2 = m_lk1; m_lk1 = locked;
            if (m_wait) begin
                if (!req) begin m_wait = 0; m_t = 0; end
            end else if (req) begin
                m_wait  = 1;
                m_cause = lk_now ? 2'd2 : 2'd1;
            end else if (m_t < 100000) begin
                m_t++;
            end
        end
    end

    bit mon_en = 0;
    always @(negedge clk) begin : monitor
        logic [ND-1:0] exp_r;
        logic          exp_rdy;
        if (mon_en) begin
            for (int k = 0; k < ND; k++) exp_r[k] = m_wait || (m_t < HOLD + 1 + k * GAP);
            exp_rdy = !m_wait && (m_t >= HOLD + 1 + (ND - 1) * GAP + 1);
            check("model_reset", 32'(rst_o), 32'(exp_r));
            check("model_ready", 32'(rdy_o), 32'(exp_rdy));
            check("model_cause", 32'(cause_o), 32'(m_cause));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    typedef struct {
        int            edge_n;
        logic [ND-1:0] rst;
        logic          rdy;
        logic [1:0]    cause;
    } vec_t;
    vec_t tbl[8];

    // Next posedge is edge 0 (first edge that samples locked high).
    task automatic run_por_table(input string tag);
        int cur = -1;
        for (int i = 0; i < 8; i++) begin
            while (cur < tbl[i].edge_n) begin
                @(posedge clk);
                cur++;
            end
            #1;
            check($sformatf("%s_rst_e%0d", tag, cur), 32'(rst_o), 32'(tbl[i].rst));
            check($sformatf("%s_rdy_e%0d", tag, cur), 32'(rdy_o), 32'(tbl[i].rdy));
            check($sformatf("%s_cause_e%0d", tag, cur), 32'(cause_o), 32'(tbl[i].cause));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit found;
        int r;
        tbl[0] = '{1,  3'b111, 1'b0, 2'd0};
        tbl[1] = '{10, 3'b111, 1'b0, 2'd0};
        tbl[2] = '{11, 3'b110, 1'b0, 2'd0};
        tbl[3] = '{12, 3'b110, 1'b0, 2'd0};
        tbl[4] = '{13, 3'b100, 1'b0, 2'd0};
        tbl[5] = '{14, 3'b100, 1'b0, 2'd0};
        tbl[6] = '{15, 3'b000, 1'b0, 2'd0};
        tbl[7] = '{16, 3'b000, 1'b1, 2'd0};

        #1 reset_n = 1'b0;
        #1;
        check("reset_state_rst", 32'(rst_o), 32'h7);
        check("reset_state_rdy", 32'(rdy_o), 32'h0);
        check("reset_state_cause", 32'(cause_o), 32'h0);
        mon_en = 1;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        locked = 1'b1;
        run_por_table("por");

        // Short bounce must not disturb RUN.
        tick(2);
        btn[1] = 1'b0; tick(3); btn[1] = 1'b1;
        tick(10);
        check("bounce_rst", 32'(rst_o), 32'h0);
        check("bounce_rdy", 32'(rdy_o), 32'h1);

        // Held press resets everything and records BUTTON.
        btn[1] = 1'b0; tick(8);
        check("press_rst", 32'(rst_o), 32'h7);
        check("press_cause", 32'(cause_o), 32'h2);
        check("press_rdy", 32'(rdy_o), 32'h0);
        btn[1] = 1'b1; tick(40);
        check("press_rerun_rdy", 32'(rdy_o), 32'h1);
        check("press_rerun_rst", 32'(rst_o), 32'h0);
        check("press_cause_hold", 32'(cause_o), 32'h2);

        // Lock loss just after reset_o[0] releases.
        locked = 1'b0; tick(3); locked = 1'b1;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(posedge clk); #1;
            if (rst_o[0] == 1'b0) found = 1;
        end
        check("midrel_found_release", 32'(found), 32'h1);
        locked = 1'b0;
        @(posedge clk); #1;
        check("midrel_e1_rst", 32'(rst_o), 32'h6);
        @(posedge clk); #1;
        check("midrel_e2_rst", 32'(rst_o), 32'h4);
        @(posedge clk); #1;
        check("midrel_e3_rst", 32'(rst_o), 32'h7);
        check("midrel_e3_cause", 32'(cause_o), 32'h1);
        check("midrel_e3_rdy", 32'(rdy_o), 32'h0);
        tick(1); locked = 1'b1; tick(30);
        check("midrel_recover_rdy", 32'(rdy_o), 32'h1);

        // Lock loss and debounced press land on the same edge.
        btn[0] = 1'b0; tick(4); locked = 1'b0; tick(8);
        check("simul_cause", 32'(cause_o), 32'h1);
        check("simul_rst", 32'(rst_o), 32'h7);
        locked = 1'b1; btn = '1; tick(40);
        check("simul_recover_rdy", 32'(rdy_o), 32'h1);

        // Half-cycle asynchronous reset pulse in RUN.
        @(negedge clk); #2;
        reset_n = 1'b0; #1;
        check("async_rst", 32'(rst_o), 32'h7);
        check("async_rdy", 32'(rdy_o), 32'h0);
        check("async_cause", 32'(cause_o), 32'h0);
        #1 reset_n = 1'b1;
        run_por_table("async");

        // Randomised run against the model.
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            r = $urandom_range(0, 999);
            if (r < 4) locked = 1'b0;
            else if (r < 40) locked = 1'b1;
            for (int b = 0; b < NB; b++) begin
                r = $urandom_range(0, 999);
                if (r < 3) btn[b] = 1'b0;
                else if (r < 200) btn[b] = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0) begin
                reset_n = 1'b0; #2 reset_n = 1'b1;
            end
        end
        tick(2);
        mon_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
